// File: rtl/line_fetch_buffer_if.sv
// rtl/line_fetch_buffer_if.sv - framebuffer read port between the line fetch buffer and memory
interface line_fetch_buffer_if #(
  parameter int ADDR_W = 17
);
  logic              fb_rd_req;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic              fb_rd_gnt;
  logic              fb_rd_valid;
  logic [11:0]       fb_rd_data;

  // line buffer side: issues requests, consumes in-order returns
  modport master (
    output fb_rd_req, fb_rd_addr,
    input  fb_rd_gnt, fb_rd_valid, fb_rd_data
  );

  // memory side: grants requests, returns data in order
  modport slave (
    input  fb_rd_req, fb_rd_addr,
    output fb_rd_gnt, fb_rd_valid, fb_rd_data
  );
endinterface

// File: rtl/line_fetch_buffer.sv
// rtl/line_fetch_buffer.sv - double-banked line buffer upscaling a downscaled framebuffer for VGA; optional LINE_FETCH_TEST_PATTERN_EN
module line_fetch_buffer #(
  parameter int SCALE   = 2,
  parameter int SRC_W   = 320,
  parameter int SRC_H   = 256,
  parameter int ADDR_W  = 17,
  parameter int MAX_OUT = 4
) (
  input  logic                pixel_clk,
  input  logic                rst,
  input  logic [10:0]         X_pix,
  input  logic [10:0]         Y_pix,
  input  logic                H_visible,
  input  logic                V_visible,
`ifdef LINE_FETCH_TEST_PATTERN_EN
  input  logic                test_mode,
`endif
  output logic [11:0]         pixel_color,
  output logic                underrun,
  line_fetch_buffer_if.master fb
);

  localparam int CNT_W  = $clog2(SRC_W + 1);
  localparam int MEM_W  = $clog2(2 * SRC_W);
  localparam int LINE_W = $clog2(SRC_H + 1) + 1;
  localparam int OUT_W  = 4;

  localparam logic [CNT_W-1:0]  SRC_W_C   = CNT_W'(SRC_W);
  localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(SRC_W - 1);
  localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [LINE_W-1:0] SRC_H_C   = LINE_W'(SRC_H);
  localparam logic [ADDR_W-1:0] SRC_W_A   = ADDR_W'(SRC_W);
  localparam logic [MEM_W-1:0]  SRC_W_M   = MEM_W'(SRC_W);
  localparam logic [10:0]       X_MAX     = 11'(SRC_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cur_base_q, cur_base_d;
  logic [LINE_W-1:0] src_line_q, src_line_d;
  logic [1:0]        bank_valid_q, bank_valid_d;
  logic [11:0]       pixel_q, pixel_d;
  logic              req_q, req_d;
  logic              tgt_q, tgt_d;
  logic              pend_q, pend_d;
  logic              disp_q, disp_d;
  logic              underrun_q, underrun_d;
  logic              h_vis_q, h_vis_d;
  logic              v_vis_q, v_vis_d;

  logic [11:0]       bank_mem [2*SRC_W];

  logic              gnt_acc, val_acc, complete, busy;
  logic              start_fetch, abort_fetch, wr_en;
  logic [ADDR_W-1:0] fetch_base;
  logic [MEM_W-1:0]  wr_addr, rd_addr;
  logic [10:0]       x_sh, x_idx;
  logic [11:0]       y_ext, y_next;
  logic              y_blk_chg, frame_end, frame_start, line_swap, vis;

  // event decode from registered visibility edges and source-line boundary
  assign y_ext       = {1'b0, Y_pix};
  assign y_next      = y_ext + 12'd1;
  assign y_blk_chg   = (y_next >> SCALE) != (y_ext >> SCALE);
  assign frame_end   = v_vis_q & ~V_visible;
  assign frame_start = ~v_vis_q & V_visible;
  assign line_swap   = h_vis_q & ~H_visible & V_visible & y_blk_chg;
  assign vis         = H_visible & V_visible;
  assign x_sh        = X_pix >> SCALE;
  assign x_idx       = (x_sh > X_MAX) ? X_MAX : x_sh;
  assign rd_addr     = disp_q ? (MEM_W'(x_idx) + SRC_W_M) : MEM_W'(x_idx);
  assign wr_addr     = tgt_q ? (MEM_W'(wr_ptr_q) + SRC_W_M) : MEM_W'(wr_ptr_q);

  // fetch engine, bank swap bookkeeping and pixel output next-state
  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    issued_d     = issued_q;
    wr_ptr_d     = wr_ptr_q;
    addr_d       = addr_q;
    cur_base_d   = cur_base_q;
    src_line_d   = src_line_q;
    bank_valid_d = bank_valid_q;
    req_d        = req_q;
    tgt_d        = tgt_q;
    pend_d       = pend_q;
    disp_d       = disp_q;
    underrun_d   = underrun_q;
    h_vis_d      = H_visible;
    v_vis_d      = V_visible;
    complete     = 1'b0;
    busy         = 1'b0;
    start_fetch  = 1'b0;
    abort_fetch  = 1'b0;
    fetch_base   = '0;
    wr_en        = 1'b0;

    // returns with nothing outstanding are stray and must not underflow
    gnt_acc = req_q & fb.fb_rd_gnt;
    val_acc = fb.fb_rd_valid & (out_q != '0);

    if (gnt_acc && !val_acc) begin
      out_d = out_q + OUT_W'(1);
    end else if (!gnt_acc && val_acc) begin
      out_d = out_q - OUT_W'(1);
    end
    if (gnt_acc) begin
      issued_d = issued_q + CNT_W'(1);
      addr_d   = addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_ISSUE, ST_WAIT: begin
        if (val_acc) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + CNT_W'(1);
          if (wr_ptr_q == LAST_C) begin
            complete               = 1'b1;
            bank_valid_d[tgt_q]    = 1'b1;
            state_d                = ST_IDLE;
          end
        end
        if (state_q == ST_ISSUE && !complete && issued_d == SRC_W_C) begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // returns of an aborted fetch are dropped, never written to a bank
        if (out_d == '0) begin
          state_d  = pend_q ? ST_ISSUE : ST_IDLE;
          issued_d = '0;
          wr_ptr_d = '0;
          pend_d   = 1'b0;
        end
      end
      default: ;
    endcase

    // a bank still being filled (or waiting to be filled) is about to be displayed
    busy = (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && !complete) ||
           ((state_q == ST_DRAIN) && pend_q);

    if (frame_end) begin
      start_fetch = 1'b1;
      fetch_base  = '0;
    end else if (frame_start || line_swap) begin
      disp_d = ~disp_q;
      if (busy && (tgt_q == ~disp_q)) begin
        underrun_d = 1'b1;
      end
      if (frame_start) begin
        src_line_d = '0;
        cur_base_d = '0;
      end else begin
        src_line_d = src_line_q + LINE_W'(1);
        cur_base_d = cur_base_q + SRC_W_A;
      end
      if ((src_line_d + LINE_W'(1)) < SRC_H_C) begin
        start_fetch = 1'b1;
        fetch_base  = cur_base_d + SRC_W_A;
      end else begin
        abort_fetch = 1'b1;
      end
    end

    // any event aborts the current fetch; a drain is needed only while reads are in flight
    if (start_fetch || abort_fetch) begin
      pend_d   = start_fetch;
      issued_d = '0;
      wr_ptr_d = '0;
      if (start_fetch) begin
        tgt_d               = ~disp_d;
        bank_valid_d[tgt_d] = 1'b0;
        addr_d              = fetch_base;
      end
      if (out_d != '0) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = start_fetch ? ST_ISSUE : ST_IDLE;
        pend_d  = 1'b0;
      end
    end

    req_d = (state_d == ST_ISSUE) && (issued_d < SRC_W_C) && (out_d < MAX_OUT_C);

    pixel_d = (vis && bank_valid_q[disp_q]) ? bank_mem[rd_addr] : 12'h000;
`ifdef LINE_FETCH_TEST_PATTERN_EN
    // eight vertical colour bars replace the framebuffer image
    if (test_mode) begin
      logic [2:0] bar;
      logic [3:0] nib;
      bar     = X_pix[10:8];
      nib     = {bar[0], bar[1], bar[2], 1'b1};
      pixel_d = vis ? {bar[2] ? nib : 4'h0, bar[1] ? nib : 4'h0, bar[0] ? nib : 4'h0} : 12'h000;
    end
`endif
  end

  // state registers with asynchronous reset
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      issued_q     <= '0;
      wr_ptr_q     <= '0;
      addr_q       <= '0;
      cur_base_q   <= '0;
      src_line_q   <= '0;
      bank_valid_q <= '0;
      pixel_q      <= '0;
      req_q        <= 1'b0;
      tgt_q        <= 1'b0;
      pend_q       <= 1'b0;
      disp_q       <= 1'b0;
      underrun_q   <= 1'b0;
      h_vis_q      <= 1'b0;
      v_vis_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      issued_q     <= issued_d;
      wr_ptr_q     <= wr_ptr_d;
      addr_q       <= addr_d;
      cur_base_q   <= cur_base_d;
      src_line_q   <= src_line_d;
      bank_valid_q <= bank_valid_d;
      pixel_q      <= pixel_d;
      req_q        <= req_d;
      tgt_q        <= tgt_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      underrun_q   <= underrun_d;
      h_vis_q      <= h_vis_d;
      v_vis_q      <= v_vis_d;
    end
  end

  // line bank storage, written by in-order returns of the active fetch
  always_ff @(posedge pixel_clk) begin
    if (wr_en) begin
      bank_mem[wr_addr] <= fb.fb_rd_data;
    end
  end

  assign pixel_color   = pixel_q;
  assign underrun      = underrun_q;
  assign fb.fb_rd_req  = req_q;
  assign fb.fb_rd_addr = addr_q;

endmodule

// File: tb/tb_line_fetch_buffer.sv
// tb/tb_line_fetch_buffer.sv - directed scoreboard bench for line_fetch_buffer
module tb_line_fetch_buffer;
  localparam int ADDR_W = 17;
  localparam int SRC_W  = 320;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [10:0] X_pix, Y_pix;
  logic        H_visible, V_visible;
  logic [11:0] pixel_color;
  logic        underrun;
`ifdef LINE_FETCH_TEST_PATTERN_EN
  logic        test_mode;
`endif

  line_fetch_buffer_if #(.ADDR_W(ADDR_W)) fb ();

  line_fetch_buffer #(
    .SCALE(2), .SRC_W(SRC_W), .SRC_H(256), .ADDR_W(ADDR_W), .MAX_OUT(4)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .X_pix       (X_pix),
    .Y_pix       (Y_pix),
    .H_visible   (H_visible),
    .V_visible   (V_visible),
`ifdef LINE_FETCH_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .pixel_color (pixel_color),
    .underrun    (underrun),
    .fb          (fb)
  );

  always #5 pixel_clk = ~pixel_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int grants = 0;
  bit gnt_en = 1'b0;
  bit hold = 1'b0;
  logic [ADDR_W-1:0] addr_exp [$];
  logic [ADDR_W-1:0] mem_addr [$];
  int                mem_due  [$];
  logic [11:0]       pix_exp  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: memory model sees grants, returns word=addr[11:0] two edges after grant
  task automatic step();
    logic g;
    logic [ADDR_W-1:0] ga;
    @(negedge pixel_clk);
    g  = fb.fb_rd_req & fb.fb_rd_gnt;
    ga = fb.fb_rd_addr;
    @(posedge pixel_clk);
    #1;
    cyc++;
    if (g) begin
      grants++;
      if (addr_exp.size() > 0) check("rd_addr", 32'(ga), 32'(addr_exp.pop_front()));
      mem_addr.push_back(ga);
      mem_due.push_back(cyc + 1);
    end
    fb.fb_rd_gnt = gnt_en;
    if (!hold && mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      fb.fb_rd_valid = 1'b1;
      fb.fb_rd_data  = mem_addr[0][11:0];
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end else begin
      fb.fb_rd_valid = 1'b0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_line(input int n);
    addr_exp.delete();
    for (int i = 0; i < SRC_W; i++) addr_exp.push_back(ADDR_W'(n * SRC_W + i));
  endtask

  task automatic pix(input logic [10:0] x, input logic [11:0] exp, input string tag);
    X_pix = x;
    pix_exp.push_back(exp);
    step();
    check(tag, 32'(pixel_color), 32'(pix_exp.pop_front()));
  endtask

  initial begin
    rst = 1'b1;
    X_pix = '0; Y_pix = '0; H_visible = 1'b0; V_visible = 1'b0;
    fb.fb_rd_gnt = 1'b0; fb.fb_rd_valid = 1'b0; fb.fb_rd_data = '0;
`ifdef LINE_FETCH_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    steps(3);
    rst = 1'b0;
    step();
    check("rst_pixel", 32'(pixel_color), 0);
    check("rst_req", 32'(fb.fb_rd_req), 0);
    check("rst_addr", 32'(fb.fb_rd_addr), 0);
    check("rst_underrun", 32'(underrun), 0);

    // frame start with returns withheld: outstanding limit caps grants
    gnt_en = 1'b1; hold = 1'b1;
    expect_line(1);
    V_visible = 1'b1;
    steps(20);
    check("max_out_grants", grants, 4);
    check("max_out_req_low", 32'(fb.fb_rd_req), 0);
    gnt_en = 1'b0; hold = 1'b0;
    step();
    hold = 1'b1;
    steps(2);
    check("req_after_return", 32'(fb.fb_rd_req), 1);

    // frame end with 3 outstanding: drain, then restart line 0 at address 0
    V_visible = 1'b0;
    expect_line(0);
    step();
    check("drain_req_low", 32'(fb.fb_rd_req), 0);
    gnt_en = 1'b1;
    steps(5);
    check("drain_hold", 32'(fb.fb_rd_req), 0);
    hold = 1'b0;
    steps(345);
    check("line0_grants", grants, 324);
    check("line0_addr_left", addr_exp.size(), 0);

    // first visible line shows source line 0 upscaled by 4
    expect_line(1);
    H_visible = 1'b1; V_visible = 1'b1; X_pix = '0;
    step();
    pix(11'd0,    12'h000, "l0_x0");
    pix(11'd3,    12'h000, "l0_x3");
    pix(11'd4,    12'h001, "l0_x4");
    pix(11'd1279, 12'h13F, "l0_x1279");
    pix(11'd2047, 12'h13F, "l0_clamp");
    H_visible = 1'b0;
    pix(11'd5,    12'h000, "hblank");
    check("underrun_l0", 32'(underrun), 0);
    steps(340);

    // end of Y=3 swaps banks; line 4 shows source line 1, line 2 is fetched
    Y_pix = 11'd3; H_visible = 1'b1;
    step();
    expect_line(2);
    H_visible = 1'b0;
    step();
    Y_pix = 11'd4; H_visible = 1'b1;
    step();
    pix(11'd0, 12'h140, "l4_x0");
    pix(11'd4, 12'h141, "l4_x4");
    check("underrun_l4", 32'(underrun), 0);
    steps(340);
    check("line2_grants", grants, 964);

    // starve grants across a line time: next swap flags underrun
    gnt_en = 1'b0;
    Y_pix = 11'd7; H_visible = 1'b1;
    step();
    H_visible = 1'b0;
    step();
    steps(100);
    check("no_underrun_yet", 32'(underrun), 0);
    check("req_held", 32'(fb.fb_rd_req), 1);
    check("addr_stable", 32'(fb.fb_rd_addr), 960);
    Y_pix = 11'd11; H_visible = 1'b1;
    step();
    H_visible = 1'b0;
    step();
    check("underrun_set", 32'(underrun), 1);
    Y_pix = 11'd12; H_visible = 1'b1;
    step();
    pix(11'd0, 12'h000, "starved_bank_blank");
    V_visible = 1'b0;
    step();
    V_visible = 1'b1;
    step();
    check("underrun_sticky", 32'(underrun), 1);
    gnt_en = 1'b1;
    expect_line(1);
    steps(50);

    // reset mid-fetch; late returns must be ignored
    rst = 1'b1;
    step();
    check("mid_rst_req", 32'(fb.fb_rd_req), 0);
    check("mid_rst_addr", 32'(fb.fb_rd_addr), 0);
    check("mid_rst_underrun", 32'(underrun), 0);
    check("mid_rst_pixel", 32'(pixel_color), 0);
    rst = 1'b0;
    addr_exp.delete();
    V_visible = 1'b0; H_visible = 1'b0;
    steps(20);
    check("post_rst_req", 32'(fb.fb_rd_req), 0);
    check("post_rst_underrun", 32'(underrun), 0);

`ifdef LINE_FETCH_TEST_PATTERN_EN
    test_mode = 1'b1;
    H_visible = 1'b1; V_visible = 1'b1;
    step();
    pix(11'd0,    12'h000, "tp_bar0");
    pix(11'd256,  12'h009, "tp_bar1");
    pix(11'd1792, 12'hFFF, "tp_bar7");
    test_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
